time_slice_gen_multi: RTL
=========================

Name: time_slice_gen_multi

Overview:
- Parametrised successor of the xpu time-slice generator.
- Produces NUM_SLICE independent periodic enable windows for tx_control.
- Each slice has its own period counter, clocked either by clk or by the TSF microsecond tick.
- Adds over the previous generation:
  - shadowed (glitch-free) configuration updates at period boundary;
  - windows that wrap across the period boundary;
  - per-slice enable and tick mode;
  - TSF-load resynchronisation;
  - per-slice boundary pulses.

Parameters:
- NUM_SLICE, 4, number of slice channels (1..16).
- CNT_WIDTH, 25, width of period counter and of total/start/end values.
- IDX_WIDTH, 2, width of slice index; must satisfy 2**IDX_WIDTH >= NUM_SLICE.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous reset, active-high.
- tsf_tick  input  1  one-cycle TSF microsecond pulse.
- tsf_load_control  input  1  one-cycle pulse; resynchronise all counters.
- cfg_wren  input  1  configuration write strobe.
- cfg_idx  input  IDX_WIDTH  target slice.
- cfg_sel  input  2  field select: 0 total, 1 start, 2 end, 3 ctrl.
- cfg_data  input  CNT_WIDTH  write data; ctrl uses bit0 enable, bit1 tick_mode.
- slice_en  output  NUM_SLICE  registered window enable per slice.
- slice_boundary  output  NUM_SLICE  one-cycle pulse when a slice counter wraps to 0.

Behaviour:
- Reset (async, rst=1):
  - all counters, shadow and active total/start/end, and ctrl clear to 0;
  - slice_en = 0 and slice_boundary = 0.
  - Reset mid-period discards pending shadow writes.
- Writes:
  - cfg_wren with cfg_sel 0..2 updates that slice's shadow register only.
  - cfg_sel 3 updates ctrl immediately.
  - cfg_idx >= NUM_SLICE: write ignored.
- Commit: shadow total/start/end copy to active on the cycle the counter wraps (advance while counter == active total).
  - While a slice is disabled, commit happens every cycle, so a disabled slice always holds the latest values.
- Advance condition per slice: enable=1 and (tick_mode=0, or tsf_tick=1).
  - On advance: counter = (counter == total) ? 0 : counter+1.
  - On wrap, slice_boundary pulses in the same cycle the counter register becomes 0.
  - total = 0: counter stays 0; boundary pulses on every advance.
- Disable: counter held at 0, slice_en forced 0, no boundary pulses.
- Resync: tsf_load_control=1 forces every counter to 0 and commits shadows.
  - Takes priority over advance and over a simultaneous ctrl write of the same cycle; the ctrl write still lands.
  - No boundary pulse is generated.
- Window, computed from the registered counter value, active registers:
  - start <= end: en = (cnt >= start) && (cnt <= end).
  - start > end (wrap window): en = (cnt >= start) || (cnt <= end).
  - slice_en is registered: latency one clk after the counter value.
- Arithmetic:
  - All comparisons are unsigned CNT_WIDTH.
  - start or end greater than total is legal; that bound is simply never reached within the period.
- Simultaneous events: a shadow write in the same cycle as a commit is taken by that commit (write data bypasses into active).

Optional Feature:
- Macro: SLICE_CNT_READBACK_EN.
- When defined, adds ports:
  - rd_idx (input, IDX_WIDTH);
  - rd_counter (output, CNT_WIDTH).
- rd_counter is the counter value of slice rd_idx, registered one cycle; reset 0; out-of-range rd_idx reads 0.
- When undefined, these ports and the readback logic are absent; all other behaviour is identical.

Decomposition:
- Package time_slice_pkg holds:
  - cfg_sel encodings (SEL_TOTAL=0, SEL_START=1, SEL_END=2, SEL_CTRL=3);
  - ctrl bit positions (CTRL_EN_BIT=0, CTRL_TICK_BIT=1).
- Sub-module time_slice_channel: one slice's shadow/active registers, counter, window compare and boundary pulse.
  - Instantiated NUM_SLICE times in a generate loop.
  - The top handles index decode, resync fan-out and readback mux.

Test Plan:
- Slice0, total=9, start=2, end=4, enable, clk mode -> slice_en[0] high for 3 of every 10 cycles, one cycle after cnt=2..4; boundary every 10 cycles.
- Slice1, total=7, start=6, end=1 (wrap) -> slice_en[1] high for cnt 6,7,0,1, i.e. 4 of 8 cycles.
- Slice2, tick mode, tsf_tick every 100 clk, total=3, start=end=0 -> slice_en[2] high for 100 clk of every 400.
- Slice0 running total=9: write total=4 at cnt=5 -> current period completes to 9, then period 5 from the next wrap; no truncated window.
- tsf_load_control at arbitrary phase with slices 0..3 running -> all counters 0 the next cycle; no boundary pulse; windows realign.
- Assert rst mid-window -> slice_en=0 immediately (async); after release all slices remain disabled until a ctrl write.

Source files
------------

// File: rtl/time_slice_pkg.sv
// Shared encodings for the multi-slice time-slice generator.
// Optional counter readback is built when SLICE_CNT_READBACK_EN is defined.
package time_slice_pkg;

  typedef enum logic [1:0] {
    SEL_TOTAL = 2'd0,
    SEL_START = 2'd1,
    SEL_END   = 2'd2,
    SEL_CTRL  = 2'd3
  } cfg_sel_e;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_TICK_BIT = 1;

  typedef struct packed {
    logic tick_mode;
    logic enable;
  } slice_ctrl_t;

endpackage

// File: rtl/time_slice_channel.sv
// One slice: shadow/active period registers, period counter, window compare
// and wrap pulse. Counter port exists only when SLICE_CNT_READBACK_EN is defined.
module time_slice_channel
  import time_slice_pkg::*;
#(
  parameter int CNT_WIDTH = 25
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tsf_tick,
  input  logic                 resync,
  input  logic                 wr_en,
  input  logic [1:0]           wr_sel,
  input  logic [CNT_WIDTH-1:0] wr_data,
`ifdef SLICE_CNT_READBACK_EN
  output logic [CNT_WIDTH-1:0] counter,
`endif
  output logic                 en,
  output logic                 boundary
);

  slice_ctrl_t          ctrl;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
  logic [CNT_WIDTH-1:0] sh_total, sh_start, sh_end;
  logic [CNT_WIDTH-1:0] act_total, act_start, act_end;
  logic [CNT_WIDTH-1:0] total_nxt, start_nxt, end_nxt;
  logic                 advance, wrap, commit, in_window;

  // A write landing on a commit cycle bypasses straight into the active set.
  always_comb begin
    total_nxt = (wr_en && wr_sel == SEL_TOTAL) ? wr_data : sh_total;
    start_nxt = (wr_en && wr_sel == SEL_START) ? wr_data : sh_start;
    end_nxt   = (wr_en && wr_sel == SEL_END)   ? wr_data : sh_end;
  end

  assign advance = ctrl.enable && (!ctrl.tick_mode || tsf_tick);
  assign wrap    = advance && (cnt == act_total);
  assign commit  = resync || wrap || !ctrl.enable;

  always_comb begin
    cnt_nxt = cnt;
    if (resync || !ctrl.enable) begin
      cnt_nxt = '0;
    end else if (advance) begin
      cnt_nxt = wrap ? '0 : cnt + CNT_WIDTH'(1);
    end
  end

  // start > end describes a window that straddles the period boundary.
  always_comb begin
    if (act_start <= act_end) begin
      in_window = (cnt >= act_start) && (cnt <= act_end);
    end else begin
      in_window = (cnt >= act_start) || (cnt <= act_end);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl      <= '0;
      cnt       <= '0;
      sh_total  <= '0;
      sh_start  <= '0;
      sh_end    <= '0;
      act_total <= '0;
      act_start <= '0;
      act_end   <= '0;
      en        <= 1'b0;
      boundary  <= 1'b0;
    end else begin
      sh_total <= total_nxt;
      sh_start <= start_nxt;
      sh_end   <= end_nxt;
      if (commit) begin
        act_total <= total_nxt;
        act_start <= start_nxt;
        act_end   <= end_nxt;
      end
      if (wr_en && wr_sel == SEL_CTRL) begin
        ctrl.enable    <= wr_data[CTRL_EN_BIT];
        ctrl.tick_mode <= wr_data[CTRL_TICK_BIT];
      end
      cnt      <= cnt_nxt;
      en       <= ctrl.enable && in_window;
      boundary <= wrap && !resync;
    end
  end

`ifdef SLICE_CNT_READBACK_EN
  assign counter = cnt;
`endif

endmodule

// File: rtl/time_slice_gen_multi.sv
// NUM_SLICE independent periodic enable windows for tx_control.
// Define SLICE_CNT_READBACK_EN to add the rd_idx/rd_counter readback port.
module time_slice_gen_multi
  import time_slice_pkg::*;
#(
  parameter int NUM_SLICE = 4,
  parameter int CNT_WIDTH = 25,
  parameter int IDX_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tsf_tick,
  input  logic                 tsf_load_control,
  input  logic                 cfg_wren,
  input  logic [IDX_WIDTH-1:0] cfg_idx,
  input  logic [1:0]           cfg_sel,
  input  logic [CNT_WIDTH-1:0] cfg_data,
`ifdef SLICE_CNT_READBACK_EN
  input  logic [IDX_WIDTH-1:0] rd_idx,
  output logic [CNT_WIDTH-1:0] rd_counter,
`endif
  output logic [NUM_SLICE-1:0] slice_en,
  output logic [NUM_SLICE-1:0] slice_boundary
);

  logic [NUM_SLICE-1:0] wr_hit;

`ifdef SLICE_CNT_READBACK_EN
  logic [CNT_WIDTH-1:0] cnt_arr [NUM_SLICE];
  logic [CNT_WIDTH-1:0] rd_mux;
`endif

  // Indices at or above NUM_SLICE match no channel, so those writes vanish.
  for (genvar i = 0; i < NUM_SLICE; i++) begin : g_slice
    assign wr_hit[i] = cfg_wren && (cfg_idx == IDX_WIDTH'(i));

    time_slice_channel #(
      .CNT_WIDTH (CNT_WIDTH)
    ) u_channel (
      .clk      (clk),
      .rst      (rst),
      .tsf_tick (tsf_tick),
      .resync   (tsf_load_control),
      .wr_en    (wr_hit[i]),
      .wr_sel   (cfg_sel),
      .wr_data  (cfg_data),
`ifdef SLICE_CNT_READBACK_EN
      .counter  (cnt_arr[i]),
`endif
      .en       (slice_en[i]),
      .boundary (slice_boundary[i])
    );
  end

`ifdef SLICE_CNT_READBACK_EN
  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < NUM_SLICE; k++) begin
      if (rd_idx == IDX_WIDTH'(k)) rd_mux = cnt_arr[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_counter <= '0;
    else     rd_counter <= rd_mux;
  end
`endif

endmodule
